// File: rtl/mips_data_bus.sv
// mips_data_bus
//   Data-side memory system for the single-cycle MIPS core. Decodes the core's
//   byte address into a word RAM or a memory-mapped I/O page.
//   The I/O page holds an LED register, a free-running cycle counter, and a TX
//   byte FIFO that is drained over a valid/ready stream. Illegal writes set a
//   sticky error flag.
//
//   I/O map (word aligned):
//     0xFFFF_FF00  LED     read/write
//     0xFFFF_FF04  CYCLE   read/write
//     0xFFFF_FF08  TXDATA  write only, reads 0
//     0xFFFF_FF0C  STATUS  read only; writing 1 to bit 2 clears overflow
//
// Ports
//   clk         system clock; all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   mem_write   core store strobe
//   alu_out     byte address from the core
//   write_data  store data from the core
//   read_data   load data to the core, combinational from alu_out
//   led         LED register contents
//   tx_data     FIFO head byte (0 when the FIFO is empty)
//   tx_valid    FIFO non-empty
//   tx_ready    sink accepts tx_data when tx_valid && tx_ready
//   bus_error   sticky flag: an illegal write occurred
module mips_data_bus #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_write,
    input  logic [31:0]      alu_out,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    output logic [LED_W-1:0] led,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             bus_error
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          io_page;
    logic [5:0]    io_sel;
    logic          sel_led;
    logic          sel_cycle;
    logic          sel_tx;
    logic          sel_status;
    logic          aligned;
    logic          wr_legal;
    logic          wr_illegal;

    assign ram_idx    = alu_out[AW+1:2];
    assign ram_hit    = (alu_out[31:AW+2] == '0);
    assign io_page    = (alu_out[31:8] == 24'hFF_FFFF);
    assign io_sel     = alu_out[7:2];
    assign sel_led    = io_page && (io_sel == 6'd0);
    assign sel_cycle  = io_page && (io_sel == 6'd1);
    assign sel_tx     = io_page && (io_sel == 6'd2);
    assign sel_status = io_page && (io_sel == 6'd3);
    assign aligned    = (alu_out[1:0] == 2'b00);

    // A write is legal only when aligned and aimed at a mapped location;
    // anything else leaves all state untouched and trips bus_error.
    assign wr_legal   = mem_write && aligned &&
                        (ram_hit || sel_led || sel_cycle || sel_tx || sel_status);
    assign wr_illegal = mem_write && !wr_legal;

    // ------------------------------------------------------------------
    // RAM (contents intentionally not reset)
    // ------------------------------------------------------------------
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_legal && ram_hit)
            ram[ram_idx] <= write_data;
    end

    // ------------------------------------------------------------------
    // LED, cycle counter, sticky error
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led       <= '0;
            cycle_cnt <= '0;
            bus_error <= 1'b0;
        end else begin
            if (wr_legal && sel_led)
                led <= write_data[LED_W-1:0];
            // A store to CYCLE takes priority over the increment in that cycle.
            if (wr_legal && sel_cycle)
                cycle_cnt <= write_data;
            else
                cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_illegal)
                bus_error <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign pop      = tx_valid && tx_ready;
    assign push_req = wr_legal && sel_tx;
    // When full, a push only fits if the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    // Storage is never reset, so mask the head while empty.
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok)
                overflow <= 1'b1;
            else if (wr_legal && sel_status && write_data[2])
                overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational; offset bits [1:0] ignored)
    // ------------------------------------------------------------------
    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = ram[ram_idx];
        end else if (sel_led) begin
            read_data[LED_W-1:0] = led;
        end else if (sel_cycle) begin
            read_data = cycle_cnt;
        end else if (sel_status) begin
            read_data[0]   = full;
            read_data[1]   = empty;
            read_data[2]   = overflow;
            read_data[7:3] = 5'(count);
        end
    end

endmodule
